// File: rtl/uart_sram_loader_pkg.sv
// Shared types and sizes for the UART-to-SRAM image loader.
package uart_sram_loader_pkg;

    localparam int BYTE_W = 8;
    localparam int LEN_W  = 16;
    localparam int WORD_W = 32;

    // Serial receiver states.
    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // Frame loader states.
    typedef enum logic [2:0] {
        L_LEN_HI,
        L_LEN_LO,
        L_DATA,
        L_WRITE,
        L_CSUM,
        L_DONE,
        L_ERR
    } ld_state_t;

    // Running checksum is a plain XOR over every byte before the CSUM byte.
    function automatic logic [BYTE_W-1:0] csum_next(input logic [BYTE_W-1:0] c,
                                                    input logic [BYTE_W-1:0] b);
        return c ^ b;
    endfunction

endpackage

// File: rtl/uart_sram_loader_if.sv
// Write-port bus between the loader and the SRAM controller.
// Handshake: a word is transferred while sram_mem_wr_en is high; the loader
// keeps sram_mem_addr and sram_mem_wr_data stable for the whole high phase.
interface uart_sram_loader_if #(
    parameter int ADDR_WIDTH = 20
) ();
    import uart_sram_loader_pkg::*;

    logic                  sram_mem_wr_en;
    logic [ADDR_WIDTH-1:0] sram_mem_addr;
    logic [WORD_W-1:0]     sram_mem_wr_data;

    modport master (
        output sram_mem_wr_en,
        output sram_mem_addr,
        output sram_mem_wr_data
    );

    modport slave (
        input sram_mem_wr_en,
        input sram_mem_addr,
        input sram_mem_wr_data
    );
endinterface

// File: rtl/uart_sram_loader_rx.sv
// 8N1 UART receiver: 2-flop input synchronizer plus a mid-bit sampling FSM.
// Emits a one-cycle byte_valid with rx_byte, or a one-cycle frame_err when
// the stop bit is sampled low.
module uart_rx_8n1
    import uart_sram_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 54
) (
    input  logic              clk_div8,
    input  logic              rst_n,
    input  logic              uart_rxd,
    output logic              byte_valid,
    output logic [BYTE_W-1:0] rx_byte,
    output logic              frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic              r_sync1;
    logic              r_sync2;
    rx_state_t         r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_bit_idx;
    logic [BYTE_W-1:0] r_shift;
    logic              r_byte_valid;
    logic              r_frame_err;

    // Bring the asynchronous line into the clock domain; idle level is high.
    always_ff @(posedge clk_div8 or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= uart_rxd;
            r_sync2 <= r_sync1;
        end
    end

    // Receiver FSM with registered one-cycle result pulses.
    always_ff @(posedge clk_div8 or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= RX_IDLE;
            r_cnt        <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    r_cnt <= '0;
                    if (!r_sync2) begin
                        r_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (r_cnt == HALF_LAST) begin
                        r_cnt <= '0;
                        // A start bit that is gone by mid-bit was only a glitch.
                        if (!r_sync2) begin
                            r_state   <= RX_DATA;
                            r_bit_idx <= '0;
                        end else begin
                            r_state <= RX_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (r_cnt == BIT_LAST) begin
                        r_cnt   <= '0;
                        r_shift <= {r_sync2, r_shift[BYTE_W-1:1]};
                        if (r_bit_idx == 3'd7) begin
                            r_state <= RX_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (r_cnt == BIT_LAST) begin
                        r_cnt   <= '0;
                        r_state <= RX_IDLE;
                        if (r_sync2) begin
                            r_byte_valid <= 1'b1;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

    assign byte_valid = r_byte_valid;
    assign rx_byte    = r_shift;
    assign frame_err  = r_frame_err;

endmodule

// File: rtl/uart_sram_loader.sv
// Receives a length-prefixed, XOR-checksummed image over UART and writes it
// word by word to the SRAM controller write port. Status feeds board LEDs.
module uart_sram_loader
    import uart_sram_loader_pkg::*;
#(
    parameter int                    CLKS_PER_BIT = 54,
    parameter int                    ADDR_WIDTH   = 20,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
    parameter int                    WR_HOLD      = 4
) (
    input  logic              clk_div8,
    input  logic              rst_n,
    input  logic              uart_rxd,
    uart_sram_loader_if.master sram,
    output logic [LEN_W-1:0]  words_loaded,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int HOLD_W = $clog2(WR_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(WR_HOLD - 1);

    logic              w_byte_valid;
    logic [BYTE_W-1:0] w_rx_byte;
    logic              w_frame_err;
    logic [LEN_W-1:0]  w_words_next;

    ld_state_t             r_state;
    logic [LEN_W-1:0]      r_len;
    logic [1:0]            r_idx;
    logic [WORD_W-1:0]     r_asm;
    logic [HOLD_W-1:0]     r_hold_cnt;
    logic [BYTE_W-1:0]     r_csum;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [WORD_W-1:0]     r_wr_data;
    logic [LEN_W-1:0]      r_words;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;

    uart_rx_8n1 #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk_div8   (clk_div8),
        .rst_n      (rst_n),
        .uart_rxd   (uart_rxd),
        .byte_valid (w_byte_valid),
        .rx_byte    (w_rx_byte),
        .frame_err  (w_frame_err)
    );

    assign w_words_next = r_words + 1'b1;

    // Loader FSM: length, data assembly, timed write, checksum, sticky status.
    always_ff @(posedge clk_div8 or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= L_LEN_HI;
            r_len      <= '0;
            r_idx      <= '0;
            r_asm      <= '0;
            r_hold_cnt <= '0;
            r_csum     <= '0;
            r_wr_en    <= 1'b0;
            r_addr     <= BASE_ADDR;
            r_wr_data  <= '0;
            r_words    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else if (w_frame_err && r_state != L_DONE && r_state != L_ERR) begin
            // A broken frame aborts at once; an in-flight word is not counted.
            r_state <= L_ERR;
            r_wr_en <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b1;
        end else begin
            case (r_state)
                L_LEN_HI: begin
                    if (w_byte_valid) begin
                        r_len[LEN_W-1:BYTE_W] <= w_rx_byte;
                        r_csum                <= csum_next(r_csum, w_rx_byte);
                        r_busy                <= 1'b1;
                        r_state               <= L_LEN_LO;
                    end
                end
                L_LEN_LO: begin
                    if (w_byte_valid) begin
                        r_len[BYTE_W-1:0] <= w_rx_byte;
                        r_csum            <= csum_next(r_csum, w_rx_byte);
                        r_idx             <= '0;
                        if ({r_len[LEN_W-1:BYTE_W], w_rx_byte} == '0) begin
                            r_state <= L_CSUM;
                        end else begin
                            r_state <= L_DATA;
                        end
                    end
                end
                L_DATA: begin
                    if (w_byte_valid) begin
                        r_asm[{r_idx, 3'b000} +: BYTE_W] <= w_rx_byte;
                        r_csum                           <= csum_next(r_csum, w_rx_byte);
                        if (r_idx == 2'd3) begin
                            // Fourth byte lands straight in the output register.
                            r_wr_data  <= {w_rx_byte, r_asm[23:0]};
                            r_wr_en    <= 1'b1;
                            r_hold_cnt <= '0;
                            r_state    <= L_WRITE;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                L_WRITE: begin
                    // No byte can arrive here: the hold is shorter than a byte time.
                    if (r_hold_cnt == HOLD_LAST) begin
                        r_wr_en <= 1'b0;
                        r_addr  <= r_addr + ADDR_WIDTH'(4);
                        r_words <= w_words_next;
                        r_idx   <= '0;
                        if (w_words_next == r_len) begin
                            r_state <= L_CSUM;
                        end else begin
                            r_state <= L_DATA;
                        end
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                L_CSUM: begin
                    if (w_byte_valid) begin
                        r_busy <= 1'b0;
                        if (w_rx_byte == r_csum) begin
                            r_done  <= 1'b1;
                            r_state <= L_DONE;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= L_ERR;
                        end
                    end
                end
                L_DONE: begin
                    r_busy <= 1'b0;
                end
                L_ERR: begin
                    r_busy  <= 1'b0;
                    r_wr_en <= 1'b0;
                end
                default: r_state <= L_ERR;
            endcase
        end
    end

    assign sram.sram_mem_wr_en   = r_wr_en;
    assign sram.sram_mem_addr    = r_addr;
    assign sram.sram_mem_wr_data = r_wr_data;
    assign words_loaded          = r_words;
    assign busy                  = r_busy;
    assign done                  = r_done;
    assign err                   = r_err;

endmodule
